apb_traffic_regfile: RTL
========================

# apb_traffic_regfile

Parametrised APB slave register bank for the traffic-light controller, successor to the fixed four-register file. Provides control, sticky status with interrupt, and a configurable number of timer profiles. Adds byte strobes, programmable wait states (pready), and error response (pslverr). Sits between the APB interconnect and the light-sequencer FSM, which consumes `ctl_o` and `active_timer_o` and drives `hw_state_i`.

## Interface
- `NUM_TIMERS`, default 2: number of TIMER_i registers. Legal range 1..8.
- `WAIT_STATES`, default 0: extra ACCESS cycles with pready low. Legal range 0..3.
- `ADDR_W`, default 8: width of paddr. Must be at least 6.
- `pclk`, in, 1: the only clock.
- `presetn`, in, 1: asynchronous, active-low reset.
- `paddr`, in, ADDR_W: byte address.
- `psel`, `penable`, `pwrite`, in, 1 each: APB control.
- `pwdata`, in, 32: write data.
- `pstrb`, in, 4: byte write strobes.
- `prdata`, out, 32: read data.
- `pready`, out, 1: transfer complete.
- `pslverr`, out, 1: error response. Valid only while pready=1.
- `hw_state_i`, in, 2: current light state from the sequencer.
- `ctl_o`, out, 3: {blink_red, blink_yellow, mod_en}.
- `profile_o`, out, 3: selected timer profile.
- `active_timer_o`, out, 32: TIMER[profile_o].
- `irq_o`, out, 1: state-change interrupt.

## Operation
- **Register map** (word aligned). Reset values apply on presetn low.
  - 0x00 CTL, RW, reset 0.
    - Bit 0: mod_en. Bit 1: blink_yellow. Bit 2: blink_red.
    - Bits 6:4: profile.
    - All other bits read 0.
  - 0x04 STAT.
    - Bits 1:0: last sampled hw_state_i, read-only, reset 0.
    - Bit 8: state_chg, sticky, write-1-to-clear, reset 0.
  - 0x08 IRQ_EN, RW, bit 0, reset 0.
  - 0x10+4·i TIMER_i, RW, for i < NUM_TIMERS. Field layout: g2y[31:20], r2g[19:8], y2r[7:0].
    - Reset values: TIMER_0 = 0xCAFE_1234, TIMER_1 = 0xFACE_5678, others 0.
- **Writes** take effect at the completing edge (psel & penable & pready & pwrite).
  - Only bytes with pstrb set are updated.
  - A STAT write clears state_chg only if pstrb[1]=1 and pwdata[8]=1. Bits 1:0 ignore writes.
- **pslverr=1** for any of the following. No register changes on an errored write.
  - An unmapped address, including TIMER_i with i ≥ NUM_TIMERS.
  - paddr[1:0] ≠ 0.
  - A CTL write with pstrb[0]=1 and pwdata[6:4] ≥ NUM_TIMERS.
- **Reads**
  - prdata = selected register while psel & penable & pready & !pwrite; otherwise 0 (never Z).
  - An errored read returns 0.
  - A read returns the pre-edge value; there is no bypass from a same-cycle write.
- **Status sampling**
  - STAT[1:0] ← hw_state_i every cycle.
  - state_chg is set when hw_state_i ≠ STAT[1:0].
  - If set and W1C clear happen on the same edge, set wins.
- **Outputs**
  - irq_o = state_chg & IRQ_EN[0], driven from flops.
  - active_timer_o is a mux of registered TIMERs by CTL.profile.
- **Wait-state FSM**
  - States:
    - IDLE: wcnt=0.
    - WAIT: wcnt counts 1..WAIT_STATES.
  - pready = psel & penable & (wcnt == WAIT_STATES).
  - IDLE → WAIT when psel & penable & WAIT_STATES > 0, setting wcnt=1.
  - WAIT: wcnt increments each cycle until pready. After the completing edge: → IDLE, wcnt=0.
  - psel or penable dropping while in WAIT aborts the transfer: → IDLE, nothing written.

## Timing
- All outputs reset asynchronously on presetn=0: prdata=0, pready=0, pslverr=0, ctl_o=0, profile_o=0, active_timer_o=0xCAFE_1234, irq_o=0. FSM goes to IDLE.
- Reset asserted mid-transfer kills the transfer; no partial write.
- Reset is released synchronously into the design through the normal async flops.
- **Transfer length**
  - With WAIT_STATES=0, pready is high in the first ACCESS cycle, so a transfer is 2 cycles (SETUP + ACCESS).
  - With WAIT_STATES=N, pready rises in the (N+1)th ACCESS cycle, so a transfer is N+2 cycles.
- ctl_o, profile_o and active_timer_o update one cycle after the completing write edge, i.e. they are visible in the cycle after pready.
- **Interrupt latency**
  - hw_state_i change → state_chg=1 and irq_o at the next edge: 1 cycle latency.
  - Clearing via W1C drops irq_o one cycle after pready.
- Back-to-back transfers (SETUP immediately after completion) are supported with no idle cycle.

## Test plan
- **Reset values:** reset, then read 0x00/0x04/0x08/0x10/0x14 → 0, 0, 0, 0xCAFE_1234, 0xFACE_5678. pslverr=0 on every read.
- **Byte-strobe write:** write 0x10 = 0x1122_3344 with pstrb=4'b0101 → readback 0xCA22_1244. With WAIT_STATES=2, pready is low for 2 ACCESS cycles, then high.
- **Profile select:** write CTL=0x0000_0011 → profile_o=1, active_timer_o=0xFACE_5678, ctl_o=3'b001. With NUM_TIMERS=2, write CTL=0x20 → pslverr=1 and CTL unchanged.
- **Error cases:** read 0x18 (NUM_TIMERS=2), read 0x02, write 0x3C → pslverr=1 and prdata=0 in each case; no register changes.
- **Interrupt:** IRQ_EN=1, hw_state_i 0→2 → irq_o=1 one cycle later and STAT=0x102. Write STAT pwdata=0x100 → irq_o=0. Repeat with a hw_state_i change on the clearing edge → state_chg stays 1.
- **Abort:** with WAIT_STATES=3, drop psel mid-write → target register unchanged and FSM back in IDLE. Assert presetn=0 mid-read → all outputs at reset values immediately.

Source files
------------

// File: rtl/apb_traffic_regfile_if.sv
// APB bus bundle between the interconnect (master) and the traffic-light
// register bank (slave).
interface apb_traffic_regfile_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_traffic_regfile.sv
// APB register bank for the traffic-light sequencer: control, sticky status
// with interrupt, NUM_TIMERS timer profiles, byte strobes, wait states, pslverr.
module apb_traffic_regfile #(
  parameter int NUM_TIMERS  = 2,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic                   pclk,
  input  logic                   presetn,
  apb_traffic_regfile_if.slave   apb,
  input  logic [1:0]             hw_state_i,
  output logic [2:0]             ctl_o,
  output logic [2:0]             profile_o,
  output logic [31:0]            active_timer_o,
  output logic                   irq_o
);

  localparam logic [1:0] WAIT_MAX = 2'(WAIT_STATES);
  localparam logic [3:0] NUM_T    = 4'(NUM_TIMERS);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  function automatic logic [31:0] timer_rst(int i);
    case (i)
      0:       return 32'hCAFE_1234;
      1:       return 32'hFACE_5678;
      default: return 32'h0;
    endcase
  endfunction

  state_e      state_q;
  logic [1:0]  wcnt_q;

  logic [2:0]  ctl_q,     ctl_d;
  logic [2:0]  profile_q, profile_d;
  logic        irq_en_q,  irq_en_d;
  logic [1:0]  hw_q,      hw_d;
  logic        chg_q,     chg_d;
  logic        irq_q,     irq_d;
  logic [31:0] timer_q [NUM_TIMERS];
  logic [31:0] timer_d [NUM_TIMERS];

  logic [ADDR_W-1:0]     addr;
  logic [3:0]            idx;
  logic                  access, ready, err, wr_en;
  logic                  is_ctl, is_stat, is_irqen, bad_prof, mapped;
  logic [NUM_TIMERS-1:0] timer_hit;
  logic [31:0]           rd_data;

  assign addr   = apb.paddr;
  assign idx    = addr[5:2];
  assign access = apb.psel & apb.penable;
  // Gated by presetn so the bus side reads idle the instant reset asserts.
  assign ready  = presetn & access & (wcnt_q == WAIT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: if (access && WAIT_STATES > 0) begin
          state_q <= S_WAIT;
          wcnt_q  <= 2'd1;
        end
        S_WAIT: if (!access || ready) begin
          state_q <= S_IDLE;
          wcnt_q  <= 2'd0;
        end else begin
          wcnt_q  <= wcnt_q + 2'd1;
        end
        default: begin
          state_q <= S_IDLE;
          wcnt_q  <= 2'd0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    timer_hit = '0;
    for (int i = 0; i < NUM_TIMERS; i++) timer_hit[i] = (idx == 4'(4 + i));
  end

  assign is_ctl   = (idx == 4'd0);
  assign is_stat  = (idx == 4'd1);
  assign is_irqen = (idx == 4'd2);
  assign mapped   = ((addr >> 6) == '0) && (addr[1:0] == 2'b00) &&
                    (is_ctl || is_stat || is_irqen || (|timer_hit));
  assign bad_prof = apb.pwrite & is_ctl & apb.pstrb[0] &
                    ({1'b0, apb.pwdata[6:4]} >= NUM_T);
  assign err      = !mapped | bad_prof;
  assign wr_en    = ready & apb.pwrite & !err;

  always_comb begin
    rd_data = '0;
    if (is_ctl)   rd_data = {25'd0, profile_q, 1'b0, ctl_q};
    if (is_stat)  rd_data = {23'd0, chg_q, 6'd0, hw_q};
    if (is_irqen) rd_data = {31'd0, irq_en_q};
    for (int i = 0; i < NUM_TIMERS; i++)
      if (timer_hit[i]) rd_data = timer_q[i];
  end

  assign apb.prdata  = (ready & !apb.pwrite & !err) ? rd_data : 32'd0;
  assign apb.pslverr = ready & err;
  assign apb.pready  = ready;

  always_comb begin
    ctl_d     = ctl_q;
    profile_d = profile_q;
    irq_en_d  = irq_en_q;
    timer_d   = timer_q;
    hw_d      = hw_state_i;
    chg_d     = chg_q;
    if (wr_en && is_ctl && apb.pstrb[0]) begin
      ctl_d     = apb.pwdata[2:0];
      profile_d = apb.pwdata[6:4];
    end
    if (wr_en && is_irqen && apb.pstrb[0]) irq_en_d = apb.pwdata[0];
    for (int i = 0; i < NUM_TIMERS; i++)
      for (int b = 0; b < 4; b++)
        if (wr_en && timer_hit[i] && apb.pstrb[b])
          timer_d[i][8*b +: 8] = apb.pwdata[8*b +: 8];
    if (wr_en && is_stat && apb.pstrb[1] && apb.pwdata[8]) chg_d = 1'b0;
    // A new hardware state on the clearing edge must not be lost.
    if (hw_state_i != hw_q) chg_d = 1'b1;
    irq_d = chg_d & irq_en_d;
  end

  // NOTE: the timer array holds configuration with defined power-on values,
  // so it is reset like ordinary flops rather than treated as RAM.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctl_q     <= 3'd0;
      profile_q <= 3'd0;
      irq_en_q  <= 1'b0;
      hw_q      <= 2'd0;
      chg_q     <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_TIMERS; i++) timer_q[i] <= timer_rst(i);
    end else begin
      ctl_q     <= ctl_d;
      profile_q <= profile_d;
      irq_en_q  <= irq_en_d;
      hw_q      <= hw_d;
      chg_q     <= chg_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NUM_TIMERS; i++) timer_q[i] <= timer_d[i];
    end
  end

  always_comb begin
    active_timer_o = timer_q[0];
    for (int i = 0; i < NUM_TIMERS; i++)
      if (profile_q == 3'(i)) active_timer_o = timer_q[i];
  end

  assign ctl_o     = ctl_q;
  assign profile_o = profile_q;
  assign irq_o     = irq_q;

endmodule
